// File: rtl/adder_share_sequencer.sv
// Shares one 4-bit ripple adder slice between two requesters.
// Each operation is computed one nibble per clock, LSB first.
// Requests are arbitrated round-robin. Results go out on a single
// response port that supports backpressure.

// Team 4-bit structural ripple adder slice.
module Adder4BitStructural (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[4];
endmodule

module adder_share_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*WORDS-1:0]   req0_a,
    input  logic [4*WORDS-1:0]   req0_b,
    input  logic                 req0_sub,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*WORDS-1:0]   req1_a,
    input  logic [4*WORDS-1:0]   req1_b,
    input  logic                 req1_sub,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [4*WORDS-1:0]   resp_sum,
    output logic                 resp_cout,
    output logic                 resp_ovf
);
    localparam int W  = 4 * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;      // B, already inverted for subtract
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic          carry;
    logic          id_reg;
    logic          last_grant;

    logic [3:0]    slice_a;
    logic [3:0]    slice_b;
    logic          slice_cin;
    logic [3:0]    slice_sum;
    logic          slice_cout;

    Adder4BitStructural u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (slice_cin),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req0_ready || req1_ready) state_next = ADD;
            ADD:     if (cnt == LAST)              state_next = DONE;
            DONE:    if (resp_ready)               state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: round-robin readies in IDLE, nibble selection into the slice in ADD
    always_comb begin
        req0_ready = '0;
        req1_ready = '0;
        slice_a    = '0;
        slice_b    = '0;
        slice_cin  = '0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_grant)) req0_ready = 1'b1;
                else if (req1_valid)                           req1_ready = 1'b1;
            end
            ADD: begin
                for (int unsigned k = 0; k < WORDS; k++) begin
                    if (cnt == CW'(k)) begin
                        slice_a = a_reg[4*k +: 4];
                        slice_b = b_reg[4*k +: 4];
                    end
                end
                slice_cin = carry;
            end
            default: ;
        endcase
    end

    // Merge the current slice sum into nibble cnt of the accumulating result
    always_comb begin
        acc_next = acc;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (cnt == CW'(k)) acc_next[4*k +: 4] = slice_sum;
        end
    end

    // Datapath: operand capture, nibble accumulation, registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            resp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req1_ready) begin
                        a_reg      <= req1_a;
                        b_reg      <= req1_sub ? ~req1_b : req1_b;
                        carry      <= req1_sub;
                        id_reg     <= 1'b1;
                        last_grant <= 1'b1;
                        cnt        <= '0;
                    end else if (req0_ready) begin
                        a_reg      <= req0_a;
                        b_reg      <= req0_sub ? ~req0_b : req0_b;
                        carry      <= req0_sub;
                        id_reg     <= 1'b0;
                        last_grant <= 1'b0;
                        cnt        <= '0;
                    end
                end
                ADD: begin
                    acc   <= acc_next;
                    carry <= slice_cout;
                    if (cnt == LAST) begin
                        // The final nibble is folded in here so the response
                        // registers load in the same edge that enters DONE.
                        cnt        <= '0;
                        resp_valid <= 1'b1;
                        resp_id    <= id_reg;
                        resp_sum   <= acc_next;
                        resp_cout  <= slice_cout;
                        resp_ovf   <= (a_reg[W-1] == b_reg[W-1]) &&
                                      (acc_next[W-1] != a_reg[W-1]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_share_sequencer.sv
// Scoreboard bench for adder_share_sequencer: accepts push expected
// results computed with plain integer arithmetic, a separate monitor
// pops and compares whenever a response is presented.
module tb_adder_share_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_sub = 1'b0, req1_sub = 1'b0;
    logic         resp_valid, resp_id, resp_cout, resp_ovf;
    logic         resp_ready = 1'b0;
    logic [W-1:0] resp_sum;

    adder_share_sequencer #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           id;
        logic [W-1:0] sum;
        bit           cout;
        bit           ovf;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   model_last = 1'b1;
    bit   contend = 1'b0;
    int   contend_acc = 0;
    int   last_acc_cyc = 0;
    int   last_hs_cyc = 0;
    bit   hs_valid = 1'b0;
    bit   hs_check = 1'b0;
    bit   prev_valid = 1'b0;
    bit   rr_random = 1'b0;
    logic rr_fixed = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer side: fixed or random resp_ready, changed well after the edge
    always @(posedge clk) begin
        #2;
        resp_ready = rr_random ? 1'($urandom_range(0, 1)) : rr_fixed;
    end

    task automatic check(input bit ok, input string msg);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s", msg);
        end
    endtask

    // Reference: integer add/subtract modulo 2^W, signed range test for overflow
    function automatic exp_t model(input bit id, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input bit sub, input int c);
        exp_t   e;
        longint m  = longint'(1) << W;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb_ = (ub >= m / 2) ? ub - m : ub;
        longint r;
        if (!sub) begin
            e.sum  = W'((ua + ub) % m);
            e.cout = (ua + ub) >= m;
            r      = sa + sb_;
        end else begin
            e.sum  = W'((ua - ub + m) % m);
            e.cout = ua >= ub;
            r      = sa - sb_;
        end
        e.ovf     = (r > m / 2 - 1) || (r < -(m / 2));
        e.id      = id;
        e.acc_cyc = c;
        return e;
    endfunction

    // Accept monitor: arbitration model, spacing rules, pushes expected results
    always @(negedge clk) begin
        bit a0, a1, id, exp_id;
        if (rst) begin
            model_last = 1'b1;
        end else begin
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0 || a1) begin
                id     = a1;
                exp_id = (req0_valid && req1_valid) ? !model_last : req1_valid;
                check(id == exp_id, $sformatf("grant: got id %0d, required %0d", id, exp_id));
                if (hs_valid)
                    check(cyc > last_hs_cyc, $sformatf("accept_after_resp: accept cycle %0d, required > %0d",
                                                       cyc, last_hs_cyc));
                if (contend && contend_acc > 0)
                    check(cyc - last_acc_cyc == WORDS + 2,
                          $sformatf("spacing: got %0d cycles, required %0d", cyc - last_acc_cyc, WORDS + 2));
                if (id) sb.push_back(model(1'b1, req1_a, req1_b, req1_sub, cyc));
                else    sb.push_back(model(1'b0, req0_a, req0_b, req0_sub, cyc));
                model_last   = id;
                last_acc_cyc = cyc;
                contend_acc++;
            end
        end
    end

    // Response monitor: latency, data against the scoreboard, stability, ready exclusion
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
            hs_check   = 1'b0;
            hs_valid   = 1'b0;
        end else begin
            check(!(req0_ready && req1_ready), "ready_excl: got both readies 1, required at most one");
            if (hs_check) begin
                check(resp_valid == 1'b0, $sformatf("valid_drop: got resp_valid %0d, required 0", resp_valid));
                hs_check = 1'b0;
            end
            if (resp_valid) begin
                check(!req0_ready && !req1_ready,
                      $sformatf("ready_in_done: got %0d/%0d, required 0/0", req0_ready, req1_ready));
                if (sb.size() == 0) begin
                    check(1'b0, $sformatf("unexpected_resp: got resp_valid 1 id %0d sum %h, required no response",
                                          resp_id, resp_sum));
                end else begin
                    e = sb[0];
                    if (!prev_valid)
                        check(cyc - e.acc_cyc == WORDS + 1,
                              $sformatf("latency: got %0d cycles, required %0d", cyc - e.acc_cyc, WORDS + 1));
                    check(resp_id == e.id && resp_sum == e.sum && resp_cout == e.cout && resp_ovf == e.ovf,
                          $sformatf("resp: got id=%0d sum=%h cout=%0d ovf=%0d, required id=%0d sum=%h cout=%0d ovf=%0d",
                                    resp_id, resp_sum, resp_cout, resp_ovf, e.id, e.sum, e.cout, e.ovf));
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        last_hs_cyc = cyc;
                        hs_valid    = 1'b1;
                        hs_check    = 1'b1;
                    end
                end
            end
            prev_valid = resp_valid;
        end
    end

    // Present one operation and wait (bounded) until it is accepted
    task automatic issue(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit sub, input bit keep, output int waited);
        bit got = 1'b0;
        waited = 0;
        if (port == 0) begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1; end
        else           begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1; end
        while (!got && waited < 200) begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) got = 1'b1;
            else begin
                @(posedge clk); #1;
                waited++;
            end
        end
        if (!got) check(1'b0, $sformatf("accept_timeout: port %0d waited %0d cycles, required acceptance", port, waited));
        else begin @(posedge clk); #1; end
        if (!keep || !got) begin
            if (port == 0) req0_valid = 1'b0;
            else           req1_valid = 1'b0;
        end
    endtask

    task automatic drive_seq(input int port, input int n, input int max_gap, input bit keep);
        int w;
        for (int i = 0; i < n; i++) begin
            if (!keep) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
            issue(port, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), keep && (i < n - 1), w);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        if (sb.size() != 0) check(1'b0, $sformatf("drain: got %0d pending, required 0", sb.size()));
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] da [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [W-1:0] db [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
        bit           ds [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int           w;
        int           n;

        // Reset
        @(posedge clk);
        @(negedge clk);
        check(resp_valid == 1'b0, $sformatf("reset_valid: got %0d, required 0", resp_valid));
        check(!req0_ready && !req1_ready, $sformatf("reset_ready: got %0d/%0d, required 0/0", req0_ready, req1_ready));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single add, accepted immediately
        issue(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, w);
        check(w == 0, $sformatf("first_ready: got %0d wait cycles, required 0", w));
        wait_idle();

        // Carry, overflow and subtract corners on alternating ports
        for (int i = 0; i < 4; i++) begin
            issue(i % 2, da[i], db[i], ds[i], 1'b0, w);
            wait_idle();
        end

        // Contention with continuous valids
        contend = 1'b1;
        contend_acc = 0;
        fork
            drive_seq(0, 4, 0, 1'b1);
            drive_seq(1, 4, 0, 1'b1);
        join
        wait_idle();
        contend = 1'b0;

        // Backpressure for 10 cycles in DONE, then a waiting request
        rr_fixed = 1'b0;
        issue(1, 16'hA5A5, 16'h5A5B, 1'b0, 1'b0, w);
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
        check(resp_valid == 1'b1, "bp_valid: got resp_valid 0, required 1");
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        rr_fixed = 1'b1;
        issue(0, 16'h0F0F, 16'h1111, 1'b1, 1'b0, w);
        wait_idle();

        // Reset during the second ADD cycle
        issue(0, 16'h4321, 16'h1111, 1'b0, 1'b0, w);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check(resp_valid == 0 && resp_sum == '0 && resp_cout == 0 && resp_ovf == 0 && resp_id == 0,
              $sformatf("post_reset: got valid=%0d sum=%h cout=%0d ovf=%0d id=%0d, required all 0",
                        resp_valid, resp_sum, resp_cout, resp_ovf, resp_id));
        repeat (12) begin @(posedge clk); #1; end
        issue(1, 16'h8001, 16'hFFFF, 1'b1, 1'b0, w);
        wait_idle();

        // Random traffic from both requesters with random backpressure
        rr_random = 1'b1;
        fork
            drive_seq(0, 20, 3, 1'b0);
            drive_seq(1, 20, 3, 1'b0);
        join
        wait_idle();
        rr_random = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
